// File: rtl/vram_slot_arbiter.sv
// VRAM access arbiter: each slot goes to display fetch, sprite fetch or one of NUM_REQ
// toggle-handshake requesters; read data returns per requester after RD_LATENCY clocks.
module vram_slot_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int NUM_REQ    = 4,
    parameter int RR_MODE    = 0,
    parameter int RD_LATENCY = 2,
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      CLK21M,
    input  logic                      RESET,
    input  logic                      slot,
    input  logic                      draw_req,
    input  logic [ADDR_W-1:0]         draw_addr,
    input  logic                      spr_req,
    input  logic [ADDR_W-1:0]         spr_addr,
    input  logic [NUM_REQ-1:0]        req_tgl,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        ack_tgl,
    output logic [NUM_REQ*DATA_W-1:0] rd_data,
    output logic [NUM_REQ-1:0]        rd_done_tgl,
    output logic [ADDR_W-1:0]         vram_addr,
    output logic [DATA_W-1:0]         vram_dout,
    output logic                      vram_we_n,
    input  logic [DATA_W-1:0]         vram_din,
    output logic                      grant_valid,
    output logic [IDX_W-1:0]          grant_idx
);

    localparam int CW = IDX_W + 1;

    logic [ADDR_W-1:0]         vram_addr_q,   vram_addr_d;
    logic [DATA_W-1:0]         vram_dout_q,   vram_dout_d;
    logic                      vram_we_n_q,   vram_we_n_d;
    logic [NUM_REQ-1:0]        ack_tgl_q,     ack_tgl_d;
    logic [NUM_REQ*DATA_W-1:0] rd_data_q,     rd_data_d;
    logic [NUM_REQ-1:0]        rd_done_tgl_q, rd_done_tgl_d;
    logic                      grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]          grant_idx_q,   grant_idx_d;
    logic [IDX_W-1:0]          rr_ptr_q,      rr_ptr_d;

    logic [RD_LATENCY-1:0]            rd_vld_q, rd_vld_d;
    logic [RD_LATENCY-1:0][IDX_W-1:0] rd_idx_q, rd_idx_d;

    logic [NUM_REQ-1:0] pending;
    logic [IDX_W-1:0]   base;
    logic [CW-1:0]      cand;
    logic               found;
    logic [IDX_W-1:0]   win;
    logic               gnt;

    // Winner search starts at base (0 for fixed priority) and wraps past NUM_REQ-1.
    always_comb begin
        pending = req_tgl ^ ack_tgl_q;
        base    = (RR_MODE != 0) ? rr_ptr_q : '0;
        cand    = '0;
        found   = 1'b0;
        win     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, base} + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!found && pending[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        vram_addr_d   = vram_addr_q;
        vram_dout_d   = vram_dout_q;
        vram_we_n_d   = 1'b1;
        ack_tgl_d     = ack_tgl_q;
        grant_valid_d = 1'b0;
        grant_idx_d   = grant_idx_q;
        rr_ptr_d      = rr_ptr_q;
        gnt           = 1'b0;

        // Display fetch owns the bus whenever it asks, slot or not.
        if (draw_req) begin
            vram_addr_d = draw_addr;
        end else if (slot && spr_req) begin
            vram_addr_d = spr_addr;
        end else if (slot && found) begin
            gnt            = 1'b1;
            vram_addr_d    = req_addr[win*ADDR_W +: ADDR_W];
            ack_tgl_d[win] = ~ack_tgl_q[win];
            grant_valid_d  = 1'b1;
            grant_idx_d    = win;
            rr_ptr_d       = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            if (req_we[win]) begin
                vram_dout_d = req_wdata[win*DATA_W +: DATA_W];
                vram_we_n_d = 1'b0;
            end
        end
    end

    // Read return pipeline: stage 0 is loaded on the grant edge, the last stage captures vram_din.
    always_comb begin
        rd_vld_d      = '0;
        rd_idx_d      = '0;
        rd_vld_d[0]   = gnt && !req_we[win];
        rd_idx_d[0]   = win;
        for (int s = 1; s < RD_LATENCY; s++) begin
            rd_vld_d[s] = rd_vld_q[s-1];
            rd_idx_d[s] = rd_idx_q[s-1];
        end
        rd_data_d     = rd_data_q;
        rd_done_tgl_d = rd_done_tgl_q;
        if (rd_vld_q[RD_LATENCY-1]) begin
            rd_data_d[rd_idx_q[RD_LATENCY-1]*DATA_W +: DATA_W] = vram_din;
            rd_done_tgl_d[rd_idx_q[RD_LATENCY-1]] = ~rd_done_tgl_q[rd_idx_q[RD_LATENCY-1]];
        end
    end

    always_ff @(posedge CLK21M or posedge RESET) begin
        if (RESET) begin
            vram_addr_q   <= '1;
            vram_dout_q   <= '0;
            vram_we_n_q   <= 1'b1;
            ack_tgl_q     <= '0;
            rd_data_q     <= '0;
            rd_done_tgl_q <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            rr_ptr_q      <= '0;
            rd_vld_q      <= '0;
        end else begin
            vram_addr_q   <= vram_addr_d;
            vram_dout_q   <= vram_dout_d;
            vram_we_n_q   <= vram_we_n_d;
            ack_tgl_q     <= ack_tgl_d;
            rd_data_q     <= rd_data_d;
            rd_done_tgl_q <= rd_done_tgl_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            rr_ptr_q      <= rr_ptr_d;
            rd_vld_q      <= rd_vld_d;
        end
    end

    // Requester indices ride along with the valid bits and need no reset.
    always_ff @(posedge CLK21M) begin
        rd_idx_q <= rd_idx_d;
    end

    assign vram_addr   = vram_addr_q;
    assign vram_dout   = vram_dout_q;
    assign vram_we_n   = vram_we_n_q;
    assign ack_tgl     = ack_tgl_q;
    assign rd_data     = rd_data_q;
    assign rd_done_tgl = rd_done_tgl_q;
    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Bench for vram_slot_arbiter: a fixed-priority and a round-robin instance, each checked
// every cycle against a queue-based reference model, plus directed literal checks.
module tb_vram_slot_arbiter;

    localparam int ADDR_W  = 19;
    localparam int DATA_W  = 8;
    localparam int NUM_REQ = 4;
    localparam int RD_LAT  = 2;
    localparam int IDX_W   = 2;
    localparam int NI      = 2;

    logic CLK21M = 1'b0;
    logic RESET  = 1'b1;
    always #5 CLK21M = ~CLK21M;

    logic                      slot, draw_req, spr_req;
    logic [ADDR_W-1:0]         draw_addr, spr_addr;
    logic [NUM_REQ-1:0]        req_tgl   [NI];
    logic [NUM_REQ-1:0]        req_we    [NI];
    logic [NUM_REQ*ADDR_W-1:0] req_addr  [NI];
    logic [NUM_REQ*DATA_W-1:0] req_wdata [NI];

    logic [NUM_REQ-1:0]        ack_o  [NI];
    logic [NUM_REQ*DATA_W-1:0] rdd_o  [NI];
    logic [NUM_REQ-1:0]        done_o [NI];
    logic [ADDR_W-1:0]         va_o   [NI];
    logic [DATA_W-1:0]         vd_o   [NI];
    logic                      we_o   [NI];
    logic [DATA_W-1:0]         din    [NI];
    logic                      gv_o   [NI];
    logic [IDX_W-1:0]          gi_o   [NI];

    int checks = 0;
    int errors = 0;

    function automatic logic [DATA_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
        return (a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]}) + 8'h38;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        vram_slot_arbiter #(
            .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REQ(NUM_REQ),
            .RR_MODE(g), .RD_LATENCY(RD_LAT)
        ) u_dut (
            .CLK21M(CLK21M), .RESET(RESET), .slot(slot),
            .draw_req(draw_req), .draw_addr(draw_addr),
            .spr_req(spr_req), .spr_addr(spr_addr),
            .req_tgl(req_tgl[g]), .req_we(req_we[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .ack_tgl(ack_o[g]), .rd_data(rdd_o[g]), .rd_done_tgl(done_o[g]),
            .vram_addr(va_o[g]), .vram_dout(vd_o[g]), .vram_we_n(we_o[g]),
            .vram_din(din[g]), .grant_valid(gv_o[g]), .grant_idx(gi_o[g])
        );
        assign din[g] = mem_f(va_o[g]);
    end

    // Reference model: instance 0 is fixed priority, instance 1 round-robin.
    typedef struct { int inst; int idx; int due; } rd_t;
    rd_t rdq[$];
    int m_cyc = 0;
    logic [ADDR_W-1:0]  m_addr [NI];
    logic [DATA_W-1:0]  m_dout [NI];
    logic               m_we_n [NI];
    logic [NUM_REQ-1:0] m_ack  [NI];
    logic [NUM_REQ-1:0] m_done [NI];
    logic [DATA_W-1:0]  m_rd   [NI][NUM_REQ];
    logic               m_gv   [NI];
    int                 m_gidx [NI];
    int                 m_ptr  [NI];

    task automatic model_reset();
        rdq.delete();
        for (int m = 0; m < NI; m++) begin
            m_addr[m] = '1; m_dout[m] = '0; m_we_n[m] = 1'b1;
            m_ack[m] = '0; m_done[m] = '0; m_gv[m] = 1'b0;
            m_gidx[m] = 0; m_ptr[m] = 0;
            for (int i = 0; i < NUM_REQ; i++) m_rd[m][i] = '0;
        end
    endtask

    function automatic bit pend_m(input int m, input int i);
        return req_tgl[m][i] != m_ack[m][i];
    endfunction

    always @(posedge CLK21M) begin : model
        logic [DATA_W-1:0]  din_now [NI];
        logic [NUM_REQ-1:0] pend;
        rd_t e;
        int w, c;
        m_cyc++;
        if (RESET) begin
            model_reset();
        end else begin
            for (int m = 0; m < NI; m++) din_now[m] = mem_f(m_addr[m]);
            while (rdq.size() > 0 && rdq[0].due <= m_cyc) begin
                e = rdq.pop_front();
                m_rd[e.inst][e.idx] = din_now[e.inst];
                m_done[e.inst][e.idx] = ~m_done[e.inst][e.idx];
            end
            for (int m = 0; m < NI; m++) begin
                m_gv[m] = 1'b0;
                m_we_n[m] = 1'b1;
                pend = req_tgl[m] ^ m_ack[m];
                w = -1;
                for (int k = 0; k < NUM_REQ; k++) begin
                    c = (m == 1) ? (m_ptr[m] + k) % NUM_REQ : k;
                    if (w < 0 && pend[c]) w = c;
                end
                if (draw_req) begin
                    m_addr[m] = draw_addr;
                end else if (slot && spr_req) begin
                    m_addr[m] = spr_addr;
                end else if (slot && w >= 0) begin
                    m_addr[m] = req_addr[m][w*ADDR_W +: ADDR_W];
                    m_ack[m][w] = ~m_ack[m][w];
                    m_gv[m] = 1'b1;
                    m_gidx[m] = w;
                    m_ptr[m] = (w + 1) % NUM_REQ;
                    if (req_we[m][w]) begin
                        m_dout[m] = req_wdata[m][w*DATA_W +: DATA_W];
                        m_we_n[m] = 1'b0;
                    end else begin
                        rdq.push_back('{m, w, m_cyc + RD_LAT});
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge CLK21M) begin : cmp
        logic [NUM_REQ*DATA_W-1:0] exp_rd;
        #1;
        for (int m = 0; m < NI; m++) begin
            for (int i = 0; i < NUM_REQ; i++) exp_rd[i*DATA_W +: DATA_W] = m_rd[m][i];
            chk($sformatf("i%0d vram_addr", m), 64'(va_o[m]), 64'(m_addr[m]));
            chk($sformatf("i%0d vram_dout", m), 64'(vd_o[m]), 64'(m_dout[m]));
            chk($sformatf("i%0d vram_we_n", m), 64'(we_o[m]), 64'(m_we_n[m]));
            chk($sformatf("i%0d ack_tgl", m), 64'(ack_o[m]), 64'(m_ack[m]));
            chk($sformatf("i%0d rd_data", m), 64'(rdd_o[m]), 64'(exp_rd));
            chk($sformatf("i%0d rd_done_tgl", m), 64'(done_o[m]), 64'(m_done[m]));
            chk($sformatf("i%0d grant_valid", m), 64'(gv_o[m]), 64'(m_gv[m]));
            chk($sformatf("i%0d grant_idx", m), 64'(gi_o[m]), 64'(m_gidx[m]));
        end
    end

    task automatic issue(input int m, input int i, input logic we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_we[m][i] = we;
        req_addr[m][i*ADDR_W +: ADDR_W] = a;
        req_wdata[m][i*DATA_W +: DATA_W] = d;
        req_tgl[m][i] = ~req_tgl[m][i];
    endtask

    task automatic check_reset_vals(input string tag);
        for (int m = 0; m < NI; m++) begin
            chk($sformatf("%s i%0d vram_addr", tag, m), 64'(va_o[m]), 64'h7FFFF);
            chk($sformatf("%s i%0d vram_we_n", tag, m), 64'(we_o[m]), 64'h1);
            chk($sformatf("%s i%0d vram_dout", tag, m), 64'(vd_o[m]), 64'h0);
            chk($sformatf("%s i%0d ack_tgl", tag, m), 64'(ack_o[m]), 64'h0);
            chk($sformatf("%s i%0d rd_done_tgl", tag, m), 64'(done_o[m]), 64'h0);
            chk($sformatf("%s i%0d rd_data", tag, m), 64'(rdd_o[m]), 64'h0);
            chk($sformatf("%s i%0d grant_valid", tag, m), 64'(gv_o[m]), 64'h0);
            chk($sformatf("%s i%0d grant_idx", tag, m), 64'(gi_o[m]), 64'h0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        slot = 1'b0; draw_req = 1'b0; spr_req = 1'b0;
        draw_addr = '0; spr_addr = '0;
        for (int m = 0; m < NI; m++) begin
            req_tgl[m] = '0; req_we[m] = '0; req_addr[m] = '0; req_wdata[m] = '0;
        end
        RESET = 1'b1;
        repeat (3) @(negedge CLK21M);
        check_reset_vals("reset");
        RESET = 1'b0;

        // Requester 1 write
        for (int m = 0; m < NI; m++) issue(m, 1, 1'b1, 19'h01234, 8'hA5);
        slot = 1'b1;
        @(posedge CLK21M); #1;
        for (int m = 0; m < NI; m++) begin
            chk("wr vram_addr", 64'(va_o[m]), 64'h01234);
            chk("wr vram_dout", 64'(vd_o[m]), 64'hA5);
            chk("wr we_n low", 64'(we_o[m]), 64'h0);
            chk("wr ack1", 64'(ack_o[m][1]), 64'h1);
            chk("wr grant_idx", 64'(gi_o[m]), 64'h1);
            chk("wr grant_valid", 64'(gv_o[m]), 64'h1);
        end
        @(negedge CLK21M); slot = 1'b0;
        @(posedge CLK21M); #1;
        for (int m = 0; m < NI; m++) begin
            chk("wr we_n back", 64'(we_o[m]), 64'h1);
            chk("wr grant_valid drop", 64'(gv_o[m]), 64'h0);
        end
        @(negedge CLK21M);

        // Requester 2 read, data returns RD_LAT clocks after the ack
        for (int m = 0; m < NI; m++) issue(m, 2, 1'b0, 19'h40000, 8'h00);
        slot = 1'b1;
        @(posedge CLK21M); #1;
        for (int m = 0; m < NI; m++) begin
            chk("rd ack2", 64'(ack_o[m][2]), 64'h1);
            chk("rd done early0", 64'(done_o[m][2]), 64'h0);
        end
        @(negedge CLK21M); slot = 1'b0;
        @(posedge CLK21M); #1;
        for (int m = 0; m < NI; m++) chk("rd done early1", 64'(done_o[m][2]), 64'h0);
        @(posedge CLK21M); #1;
        for (int m = 0; m < NI; m++) begin
            chk("rd done2", 64'(done_o[m][2]), 64'h1);
            chk("rd data2", 64'(rdd_o[m][2*DATA_W +: DATA_W]), 64'h3C);
            chk("model rd data2", 64'(m_rd[m][2]), 64'h3C);
        end
        @(negedge CLK21M);

        // Requesters 0 and 3 pending, display then sprite take the slots
        for (int m = 0; m < NI; m++) begin
            issue(m, 0, 1'b1, 19'h00010, 8'h11);
            issue(m, 3, 1'b1, 19'h7FF00, 8'h33);
        end
        draw_req = 1'b1; draw_addr = 19'h11111; slot = 1'b1;
        @(posedge CLK21M); #1;
        for (int m = 0; m < NI; m++) begin
            chk("draw vram_addr", 64'(va_o[m]), 64'h11111);
            chk("draw ack", 64'(ack_o[m]), 64'h6);
        end
        @(negedge CLK21M);
        draw_req = 1'b0; spr_req = 1'b1; spr_addr = 19'h22222;
        @(posedge CLK21M); #1;
        for (int m = 0; m < NI; m++) begin
            chk("spr vram_addr", 64'(va_o[m]), 64'h22222);
            chk("spr ack", 64'(ack_o[m]), 64'h6);
        end
        @(negedge CLK21M);
        spr_req = 1'b0;
        @(posedge CLK21M); #1;
        chk("fixed first", 64'(gi_o[0]), 64'h0);
        chk("rr first", 64'(gi_o[1]), 64'h3);
        @(posedge CLK21M); #1;
        chk("fixed second", 64'(gi_o[0]), 64'h3);
        chk("rr second", 64'(gi_o[1]), 64'h0);
        for (int m = 0; m < NI; m++) chk("both served", 64'(ack_o[m]), 64'hF);
        @(negedge CLK21M); slot = 1'b0;
        @(negedge CLK21M);

        // Read granted, reset arrives before its data returns
        for (int m = 0; m < NI; m++) issue(m, 1, 1'b0, 19'h00ABC, 8'h00);
        slot = 1'b1;
        @(posedge CLK21M); #1;
        for (int m = 0; m < NI; m++) chk("flush ack1", 64'(ack_o[m][1]), 64'h0);
        @(negedge CLK21M); slot = 1'b0;
        @(negedge CLK21M);
        RESET = 1'b1;
        for (int m = 0; m < NI; m++) req_tgl[m] = '0;
        repeat (2) @(negedge CLK21M);
        RESET = 1'b0;
        repeat (3) @(negedge CLK21M);
        check_reset_vals("flush");

        // All requesters kept pending over 8 slots
        for (int k = 0; k < 8; k++) begin
            for (int m = 0; m < NI; m++)
                for (int i = 0; i < NUM_REQ; i++)
                    if (!pend_m(m, i)) issue(m, i, 1'b1, ADDR_W'($urandom()), DATA_W'($urandom()));
            slot = 1'b1;
            @(posedge CLK21M); #1;
            chk($sformatf("rr order %0d", k), 64'(gi_o[1]), 64'(k % 4));
            chk($sformatf("fixed order %0d", k), 64'(gi_o[0]), 64'h0);
            @(negedge CLK21M); slot = 1'b0;
            @(negedge CLK21M);
        end

        // Randomised traffic with one reset in the middle
        for (int n = 0; n < 4000; n++) begin
            if (n == 2000) begin
                RESET = 1'b1; slot = 1'b0; draw_req = 1'b0; spr_req = 1'b0;
                for (int m = 0; m < NI; m++) req_tgl[m] = '0;
                repeat (2) @(negedge CLK21M);
                RESET = 1'b0;
            end
            slot      = ($urandom_range(0, 2) == 0);
            draw_req  = ($urandom_range(0, 4) == 0);
            spr_req   = ($urandom_range(0, 3) == 0);
            draw_addr = ADDR_W'($urandom());
            spr_addr  = ADDR_W'($urandom());
            for (int m = 0; m < NI; m++)
                for (int i = 0; i < NUM_REQ; i++)
                    if (!pend_m(m, i) && $urandom_range(0, 2) == 0)
                        issue(m, i, 1'($urandom_range(0, 1)), ADDR_W'($urandom()), DATA_W'($urandom()));
            @(negedge CLK21M);
        end

        slot = 1'b0; draw_req = 1'b0; spr_req = 1'b0;
        repeat (4) @(negedge CLK21M);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_slot_arbiter.md
Name: vram_slot_arbiter

Overview:
- Parametrised VRAM access arbiter; successor to the fixed CPU/sprite/command address mux.
- Each access slot goes to one of:
  - display fetch (highest priority),
  - sprite fetch,
  - or one of NUM_REQ generic toggle-handshake requesters (CPU port, command engine, future DMA).
- Drives the VRAM address/data/write-enable bus.
- Returns read data per requester through a fixed-latency capture pipeline, so requesters no longer sample VRAM themselves.

Parameters:
- ADDR_W, 19, VRAM address width.
- DATA_W, 8, VRAM data width.
- NUM_REQ, 4, number of generic requesters, index 0..NUM_REQ-1.
- RR_MODE, 0, arbitration among generic requesters: 0 = fixed priority (lowest index wins); 1 = round-robin.
- RD_LATENCY, 2, clocks from grant edge to the vram_din sample.

Ports:
- CLK21M  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- slot  in  1  one-cycle strobe marking an arbitration slot (DOTSTATE==2'b10 equivalent)
- draw_req  in  1  display fetch wants the current slot/cycle (level)
- draw_addr  in  ADDR_W  display fetch address
- spr_req  in  1  sprite fetch wants the current slot (level)
- spr_addr  in  ADDR_W  sprite fetch address
- req_tgl  in  NUM_REQ  per-requester request toggle
- req_we  in  NUM_REQ  1 = write, 0 = read; held stable while pending
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- ack_tgl  out  NUM_REQ  per-requester grant toggle
- rd_data  out  NUM_REQ*DATA_W  per-requester captured read data
- rd_done_tgl  out  NUM_REQ  toggles when rd_data[i] has been updated
- vram_addr  out  ADDR_W  VRAM address
- vram_dout  out  DATA_W  VRAM write data
- vram_we_n  out  1  VRAM write enable, active low
- vram_din  in  DATA_W  VRAM read data
- grant_valid  out  1  1 for one clock after a generic grant
- grant_idx  out  $clog2(NUM_REQ) (minimum 1)  index of the last generic grant

Behaviour:
- Reset values:
  - vram_addr = all ones; vram_dout = 0; vram_we_n = 1.
  - ack_tgl = 0; rd_done_tgl = 0; rd_data = 0.
  - grant_valid = 0; grant_idx = 0; round-robin pointer = 0.
  - Read pipeline empty.
- Pending definition: requester i is pending iff req_tgl[i] != ack_tgl[i]. Only one outstanding request per requester.
- Non-slot cycles:
  - If draw_req: vram_addr <= draw_addr, vram_we_n <= 1.
  - Otherwise the bus holds its previous value, except that vram_we_n returns to 1.
- Slot cycle priority:
  1. draw_req → vram_addr <= draw_addr; we_n 1.
  2. Else spr_req → vram_addr <= spr_addr; we_n 1.
  3. Else any requester pending → winner w selected per RR_MODE.
  4. Else idle: bus held; we_n 1.
- Winner selection:
  - RR_MODE=0: lowest pending index.
  - RR_MODE=1: first pending index at or after the pointer, wrapping at NUM_REQ-1 → 0.
  - After each generic grant, the pointer <= (w+1) mod NUM_REQ.
  - The pointer does not move on draw, sprite, or idle slots.
- Generic grant of w (all registered on the slot edge):
  - vram_addr <= req_addr[w]; ack_tgl[w] <= ~ack_tgl[w].
  - grant_valid <= 1; grant_idx <= w.
  - Write: vram_dout <= req_wdata[w]; vram_we_n <= 0 for exactly one clock.
  - Read: vram_we_n <= 1; push {w, valid} into the read pipeline.
- Read pipeline:
  - Shift register of depth RD_LATENCY.
  - On an entry reaching the end: rd_data[w] <= vram_din; rd_done_tgl[w] toggles in the same edge.
  - Total latency: rd_done_tgl flips RD_LATENCY clocks after ack_tgl flips.
  - Back-to-back reads on consecutive slots are pipelined independently; entries never merge.
- Simultaneous events:
  - A requester re-toggling in the same cycle its ack toggles stays pending and is arbitrated at the next slot.
  - draw_req and spr_req both high: draw wins; sprite is not queued.
- Reset mid-operation: the read pipeline is flushed, and no rd_done_tgl is produced for in-flight reads.
- Width rules: addresses pass through unmodified, with no increment or masking; address auto-increment is the requester's job.

Test Plan:
- Reset, then check all outputs: vram_addr=19'h7FFFF, vram_we_n=1, ack_tgl=0, rd_done_tgl=0.
- Requester 1 write, addr 19'h01234, data 8'hA5, slot pulsed with draw_req=spr_req=0 → vram_addr=01234, vram_dout=A5, we_n low for 1 clock, ack_tgl[1] flips, grant_idx=1.
- Requester 2 read, addr 19'h40000, vram_din model returns 8'h3C; RD_LATENCY=2 → rd_data[2]=3C and rd_done_tgl[2] flip 2 clocks after ack_tgl[2].
- Requesters 0 and 3 pending; draw_req=1 on a slot → vram_addr=draw_addr, no ack changes; next slot with draw_req=0 and spr_req=1 → spr_addr, no ack changes.
- RR_MODE=1: all 4 requesters pending continuously over 8 slots → grant order 0,1,2,3,0,1,2,3. RR_MODE=0 with 0 and 3 pending → 0 wins, then 3.
- Read granted, then RESET asserted 1 clock later → no rd_done_tgl toggle; all outputs back at reset values.
